// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate in front of a single-port, word-organised SRAM.
// Handles the address/data-phase pipeline, byte-lane writes, a fixed number
// of wait states per OKAY transfer and write-to-read forwarding.
//
// Optional feature macro: AHB_SRAM_ERR_RESP_EN
//   defined   : two-cycle ERROR response for bad size, misalignment or an
//               address beyond the array; errored transfers have no effect.
//   undefined : HRESP stays 0, upper address bits are ignored (wrap),
//               misaligned accesses use size-aligned lanes, HSIZE>010 = word.
//
// Ports:
//   HCLK, HRESETn           clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS,    address phase from the decoder / master
//   HWRITE, HSIZE, HREADY
//   HWDATA                  write data, valid in the data phase
//   HREADYOUT, HRESP        data-phase completion and response (registered)
//   HRDATA                  read data (registered)
module ahb_lite_sram_slave #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
`ifdef AHB_SRAM_ERR_RESP_EN
        ,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
`endif
    } state_t;

    logic [31:0]      mem [MEM_DEPTH];

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ready_n, resp_n;
    logic             rd_done_c;

    // data-phase registers
    logic             dp_wr, dp_rd;
    logic [IDX_W-1:0] dp_idx;
    logic [3:0]       dp_lanes;
    logic [31:0]      rd_buf;

    logic             accept_c, err_c, rd_accept_c, wr_commit_c;
    logic [IDX_W-1:0] idx_c;
    logic [3:0]       lanes_c;
    logic [31:0]      merged_c, rd_word_c;
    logic             unused_c;

    assign accept_c    = HSEL && HREADY && HTRANS[1];
    assign idx_c       = HADDR[IDX_W+1:2];
    assign rd_accept_c = accept_c && !HWRITE && !err_c;
    // commit at the edge that ends the write's final (HREADYOUT=1) cycle
    assign wr_commit_c = dp_wr && HREADYOUT && HRESETn;
    assign unused_c    = ^{HTRANS[0], HADDR[31:IDX_W+2]};

    // byte lanes from size and low address bits, aligned down to the size
    always_comb begin
        lanes_c = 4'b1111;
        case (HSIZE)
            3'b000:  lanes_c = 4'b0001 << HADDR[1:0];
            3'b001:  lanes_c = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes_c = 4'b1111;
        endcase
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    assign err_c = (HSIZE > 3'b010)
                || ((HSIZE == 3'b001) && HADDR[0])
                || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                || (HADDR[31:IDX_W+2] != '0);
`else
    assign err_c = 1'b0;
`endif

    // word being committed this edge, used to forward into a same-edge read
    always_comb begin
        merged_c = mem[dp_idx];
        for (int b = 0; b < 4; b++) begin
            if (dp_lanes[b]) merged_c[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    assign rd_word_c = (wr_commit_c && (dp_idx == idx_c)) ? merged_c : mem[idx_c];

    // next-state and registered-output values
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ready_n   = 1'b1;
        resp_n    = 1'b0;
        rd_done_c = 1'b0;
        case (state)
            ST_WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n   = ST_IDLE;
                    rd_done_c = dp_rd;
                end else begin
                    ready_n = 1'b0;
                end
            end
`ifdef AHB_SRAM_ERR_RESP_EN
            ST_ERR1: begin
                state_n = ST_ERR2;
                resp_n  = 1'b1;
            end
`endif
            default: begin
                // IDLE and ERR2 are final data-phase cycles: may accept
                state_n = ST_IDLE;
`ifdef AHB_SRAM_ERR_RESP_EN
                if (accept_c && err_c) begin
                    state_n = ST_ERR1;
                    ready_n = 1'b0;
                    resp_n  = 1'b1;
                end else
`endif
                if (accept_c && (WAIT_STATES != 0)) begin
                    state_n = ST_WAIT;
                    cnt_n   = CNT_W'(WAIT_STATES);
                    ready_n = 1'b0;
                end
            end
        endcase
    end

    // control and data-phase registers
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            rd_buf    <= '0;
            dp_wr     <= 1'b0;
            dp_rd     <= 1'b0;
            dp_idx    <= '0;
            dp_lanes  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            HREADYOUT <= ready_n;
            HRESP     <= resp_n;
            if (HREADY) begin
                dp_wr    <= accept_c && HWRITE && !err_c;
                dp_rd    <= accept_c && !HWRITE && !err_c;
                dp_idx   <= idx_c;
                dp_lanes <= lanes_c;
            end
            // zero-wait reads present data immediately; otherwise park it
            if (rd_accept_c) begin
                if (WAIT_STATES == 0) HRDATA <= rd_word_c;
                else                  rd_buf <= rd_word_c;
            end
            if (rd_done_c) HRDATA <= rd_buf;
        end
    end

    // SRAM array: not reset, byte-lane writes
    always_ff @(posedge HCLK) begin
        if (wr_commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_lanes[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 2 and 3 wait states)
// share one AHB-Lite bus; a byte-addressed memory model predicts every
// response, latency and read value.
module tb_ahb_lite_sram_slave;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned NDUT  = 3;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel_bus;
    int          sel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        hready_bus;
    logic        hsel [NDUT];
    logic        ro   [NDUT];
    logic        rsp  [NDUT];
    logic [31:0] rd   [NDUT];

    always #5 HCLK = ~HCLK;

    assign hsel[0] = hsel_bus && (sel == 0);
    assign hsel[1] = hsel_bus && (sel == 1);
    assign hsel[2] = hsel_bus && (sel == 2);

    always_comb begin
        case (sel)
            0:       hready_bus = ro[0];
            1:       hready_bus = ro[1];
            default: hready_bus = ro[2];
        endcase
    end

    ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_w0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hready_bus), .HREADYOUT(ro[0]), .HRESP(rsp[0]), .HRDATA(rd[0]));
    ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u_w2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hready_bus), .HREADYOUT(ro[1]), .HRESP(rsp[1]), .HRDATA(rd[1]));
    ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_w3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hready_bus), .HREADYOUT(ro[2]), .HRESP(rsp[2]), .HRDATA(rd[2]));

    typedef struct {
        bit          idle;
        logic [1:0]  trans;
        logic        hsel;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    int          checks = 0;
    int          errors = 0;
    int          wait_of [NDUT] = '{0, 2, 3};
    logic [7:0]  mbytes  [NDUT][DEPTH*4];
    logic [31:0] last_rd [NDUT];
    logic [31:0] rd_log [$];

    // ---------------- reference model ----------------
    function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
`ifdef AHB_SRAM_ERR_RESP_EN
        if (size > 3'd2) return 1'b1;
        if (size == 3'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 3'd2 && (addr % 4) != 0) return 1'b1;
        if (addr >= DEPTH * 4) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nbytes(input logic [2:0] size);
        if (size == 3'd0) return 1;
        if (size == 3'd1) return 2;
        return 4;
    endfunction

    function automatic int unsigned base_of(input logic [31:0] addr, input logic [2:0] size);
        int unsigned a = addr % (DEPTH * 4);
        return a - (a % nbytes(size));
    endfunction

    task automatic model_write(input int d, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata);
        int unsigned b = base_of(addr, size);
        for (int k = 0; k < nbytes(size); k++) begin
            int unsigned ba = b + k;
            mbytes[d][ba] = wdata[8*(ba%4) +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
        int unsigned w = base_of(addr, 3'd2);
        return {mbytes[d][w+3], mbytes[d][w+2], mbytes[d][w+1], mbytes[d][w]};
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.idle = 0; x.trans = 2'b10; x.hsel = 1'b1;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    // ---------------- pipelined bus engine ----------------
    task automatic run_seq(input int d, input xfer_t q[$], output int ncyc);
        int    idx = 0;
        bit    dp = 0;
        bit    idle_dp = 0;
        int    waits = 0;
        xfer_t cur;
        logic  r, p;
        bit    e;
        int    ew;
        logic [31:0] exp;
        sel  = d;
        ncyc = 0;
        cur  = mk(0, 0, 0, 0);
        while (idx < q.size() || dp || idle_dp) begin
            if (idx < q.size()) begin
                hsel_bus = q[idx].idle ? q[idx].hsel : 1'b1;
                if (q[idx].idle)
                    HTRANS = q[idx].trans;
                else if (idx > 0 && !q[idx-1].idle && q[idx].addr == q[idx-1].addr + 4)
                    HTRANS = 2'b11;
                else
                    HTRANS = 2'b10;
                HADDR  = q[idx].addr;
                HWRITE = q[idx].wr;
                HSIZE  = q[idx].size;
            end else begin
                hsel_bus = 1'b0;
                HTRANS   = 2'b00;
            end
            HWDATA = dp ? cur.wdata : $urandom();
            @(negedge HCLK);
            ncyc++;
            r = hready_bus;
            p = rsp[d];
            if (idle_dp) begin
                checks++;
                if (r !== 1'b1 || p !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_slot: dut%0d ready/resp got %b/%b exp 1/0", d, r, p);
                end
                idle_dp = 0;
            end
            if (dp) begin
                e = is_err(cur.addr, cur.size);
                if (r !== 1'b1) begin
                    waits++;
                    checks++;
                    if (p !== e) begin
                        errors++;
                        $display("FAIL resp_wait: dut%0d addr %h got %b exp %b", d, cur.addr, p, e);
                    end
                    if (waits > 40) begin
                        errors++;
                        $display("FAIL timeout: dut%0d addr %h HREADYOUT stuck low", d, cur.addr);
                        dp  = 0;
                        idx = q.size();
                    end
                end else begin
                    ew = e ? 1 : wait_of[d];
                    checks++;
                    if (waits != ew) begin
                        errors++;
                        $display("FAIL latency: dut%0d addr %h got %0d exp %0d wait cycles", d, cur.addr, waits, ew);
                    end
                    checks++;
                    if (p !== e) begin
                        errors++;
                        $display("FAIL resp: dut%0d addr %h got %b exp %b", d, cur.addr, p, e);
                    end
                    if (cur.wr) begin
                        if (!e) model_write(d, cur.addr, cur.size, cur.wdata);
                    end else begin
                        exp = e ? last_rd[d] : model_read(d, cur.addr);
                        checks++;
                        if (rd[d] !== exp) begin
                            errors++;
                            $display("FAIL rdata: dut%0d addr %h got %h exp %h", d, cur.addr, rd[d], exp);
                        end
                        rd_log.push_back(rd[d]);
                        if (!e) last_rd[d] = exp;
                    end
                    dp = 0;
                end
            end
            if (r === 1'b1 && idx < q.size()) begin
                if (q[idx].idle) idle_dp = 1;
                else begin cur = q[idx]; dp = 1; waits = 0; end
                idx++;
            end
            @(posedge HCLK); #1;
        end
        hsel_bus = 1'b0;
        HTRANS   = 2'b00;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ro[d] !== 1'b1 || rsp[d] !== 1'b0 || rd[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: dut%0d ready/resp/rdata got %b/%b/%h exp 1/0/0", d, ro[d], rsp[d], rd[d]);
            end
        end
    endtask

    task automatic test_init();
        xfer_t q[$];
        int    n;
        for (int d = 0; d < NDUT; d++) begin
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(mk(1, 32'(i * 4), 3'd2, $urandom()));
            run_seq(d, q, n);
        end
    endtask

    task automatic test_forwarding();
        xfer_t q[$];
        int    n;
        rd_log.delete();
        q.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_seq(0, q, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL fwd_cycles: got %0d exp 3", n);
        end
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fwd_data: got %h exp deadbeef", rd_log.size() > 0 ? rd_log[0] : 32'hx);
        end
    endtask

    task automatic test_byte_lane();
        xfer_t q[$];
        int    n;
        rd_log.delete();
        q.push_back(mk(1, 32'h20, 3'd2, 32'h11223344));
        q.push_back(mk(1, 32'h21, 3'd0, 32'h0000AA00));
        q.push_back(mk(0, 32'h20, 3'd2, 32'h0));
        run_seq(0, q, n);
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'h1122AA44) begin
            errors++;
            $display("FAIL byte_lane: got %h exp 1122aa44", rd_log.size() > 0 ? rd_log[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        xfer_t q[$];
        int    n;
        q.push_back(mk(1, 32'h04, 3'd2, 32'hCAFEF00D));
        q.push_back(mk(1, 32'h08, 3'd2, 32'h0BADC0DE));
        run_seq(1, q, n);
        q.delete();
        rd_log.delete();
        q.push_back(mk(0, 32'h04, 3'd2, 32'h0));
        q.push_back(mk(0, 32'h08, 3'd2, 32'h0));
        run_seq(1, q, n);
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d exp 7", n);
        end
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 32'hCAFEF00D || rd_log[1] !== 32'h0BADC0DE) begin
            errors++;
            $display("FAIL b2b_data: got %h %h exp cafef00d 0badc0de",
                     rd_log.size() > 0 ? rd_log[0] : 32'hx, rd_log.size() > 1 ? rd_log[1] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_wait();
        xfer_t q[$];
        int    n;
        sel      = 2;
        hsel_bus = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h14; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        hsel_bus = 1'b0; HTRANS = 2'b00; HWDATA = 32'h12345678;
        @(negedge HCLK);
        checks++;
        if (ro[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: HREADYOUT got %b exp 0", ro[2]);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++;
        if (ro[2] !== 1'b1 || rsp[2] !== 1'b0 || rd[2] !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: ready/resp/rdata got %b/%b/%h exp 1/0/0", ro[2], rsp[2], rd[2]);
        end
        for (int d = 0; d < NDUT; d++) last_rd[d] = 32'h0;
        @(posedge HCLK); #1;
        q.push_back(mk(0, 32'h14, 3'd2, 32'h0));
        run_seq(2, q, n);
    endtask

    task automatic test_random(input int d, input int count);
        xfer_t q[$];
        xfer_t x;
        int    n, s;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                x = mk(0, $urandom(), 3'd2, 32'h0);
                x.idle  = 1;
                x.trans = $urandom_range(0, 1) ? 2'b01 : 2'b00;
                x.hsel  = 1'($urandom_range(0, 1));
            end else begin
                s = $urandom_range(0, 15);
                x = mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1) * 4), 3'd2, $urandom());
                if (s < 5)       x.size = 3'd0;
                else if (s < 9)  x.size = 3'd1;
                else if (s < 15) x.size = 3'd2;
                else             x.size = 3'($urandom_range(3, 7));
                if (x.size == 3'd0 || $urandom_range(0, 5) == 0)
                    x.addr = x.addr + 32'($urandom_range(0, 3));
                else if (x.size == 3'd1)
                    x.addr = x.addr + 32'($urandom_range(0, 1) * 2);
                if ($urandom_range(0, 9) == 0)
                    x.addr = x.addr + 32'(DEPTH * 4 * $urandom_range(1, 3));
            end
            q.push_back(x);
        end
        run_seq(d, q, n);
    endtask

`ifdef AHB_SRAM_ERR_RESP_EN
    task automatic test_error();
        xfer_t q[$];
        int    n;
        rd_log.delete();
        q.push_back(mk(0, 32'h00, 3'd2, 32'h0));
        q.push_back(mk(0, 32'h02, 3'd2, 32'h0));
        q.push_back(mk(1, 32'(DEPTH * 4), 3'd2, 32'hFFFF_FFFF));
        q.push_back(mk(0, 32'h00, 3'd2, 32'h0));
        run_seq(1, q, n);
        checks++;
        if (rd_log.size() != 3 || rd_log[2] !== rd_log[0] || rd_log[1] !== rd_log[0]) begin
            errors++;
            $display("FAIL err_nochange: reads got %h %h %h exp all %h",
                     rd_log.size() > 0 ? rd_log[0] : 32'hx, rd_log.size() > 1 ? rd_log[1] : 32'hx,
                     rd_log.size() > 2 ? rd_log[2] : 32'hx, model_read(1, 32'h0));
        end
    endtask
`else
    task automatic test_wrap();
        xfer_t q[$];
        int    n;
        rd_log.delete();
        q.push_back(mk(1, 32'(DEPTH * 4), 3'd2, 32'h0000_0055));
        q.push_back(mk(0, 32'h00, 3'd2, 32'h0));
        run_seq(0, q, n);
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'h0000_0055) begin
            errors++;
            $display("FAIL wrap: got %h exp 00000055", rd_log.size() > 0 ? rd_log[0] : 32'hx);
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; hsel_bus = 1'b0; sel = 0;
        HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0;
        for (int d = 0; d < NDUT; d++) last_rd[d] = 32'h0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        test_reset();
        @(posedge HCLK); #1;
        test_init();
        test_forwarding();
        test_byte_lane();
        test_back_to_back();
        test_reset_mid_wait();
        for (int d = 0; d < NDUT; d++) test_random(d, 60);
`ifdef AHB_SRAM_ERR_RESP_EN
        test_error();
`else
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
